keypad_hit_scanner: RTL and testbench

//  Registered, parametrised successor to the combinational click-to-key decoder.

---
 rtl/keypad_hit_scanner_if.sv | 23 ++
 rtl/keypad_hit_scanner.sv | 181 ++++++++++++++++++
 tb/tb_keypad_hit_scanner.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_hit_scanner_if.sv
// Pointer-to-keypad bus: pointer/button inputs plus the decoded key event outputs.
interface keypad_hit_scanner_if;
    logic [2:0] clicked;
    logic [9:0] Xlocation;
    logic [8:0] Ylocation;
    logic       key_valid;
    logic [3:0] key_code;
    logic       is_digit;
    logic       is_op;
    logic [2:0] key_row;
    logic [2:0] key_col;
    logic       busy;

    modport master (
        output clicked, Xlocation, Ylocation,
        input  key_valid, key_code, is_digit, is_op, key_row, key_col, busy
    );

    modport slave (
        input  clicked, Xlocation, Ylocation,
        output key_valid, key_code, is_digit, is_op, key_row, key_col, busy
    );
endinterface

// File: rtl/keypad_hit_scanner.sv
// Captures the pointer on a click edge, scans the keypad grid one cell index per cycle
// and emits a single-cycle key event. Optional auto-repeat: define KEY_REPEAT_EN.
module keypad_hit_scanner #(
    parameter int ORIGIN_X      = 175,
    parameter int ORIGIN_Y      = 190,
    parameter int CELL_W        = 63,
    parameter int CELL_H        = 63,
    parameter int COLS          = 5,
    parameter int ROWS          = 4,
    parameter int REPEAT_CYCLES = 25000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    keypad_hit_scanner_if.slave   kp
);
    localparam int D = (COLS > ROWS) ? COLS : ROWS;

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, WAIT_REL} state_t;

    state_t      state_reg, state_next;
    logic        clicked_q_reg;
    logic [11:0] x_reg, y_reg;
    logic [2:0]  idx_reg, row_reg, col_reg;
    logic        colhit_reg, rowhit_reg;
    logic        key_valid_reg, is_digit_reg, is_op_reg;
    logic [3:0]  key_code_reg;
    logic [2:0]  key_row_reg, key_col_reg;

    logic        any_click, press, scan_last, col_match, row_match;
    logic [11:0] col_lo, col_hi, row_lo, row_hi;
    logic [5:0]  lut;

    assign any_click = |kp.clicked;
    assign press     = any_click & ~clicked_q_reg;
    assign scan_last = (idx_reg == 3'(D - 1));

    // Bounds of the cell at the current scan index; strict compares make grid lines misses.
    assign col_lo    = 12'(ORIGIN_X) + 12'(idx_reg) * 12'(CELL_W);
    assign col_hi    = col_lo + 12'(CELL_W);
    assign row_lo    = 12'(ORIGIN_Y) + 12'(idx_reg) * 12'(CELL_H);
    assign row_hi    = row_lo + 12'(CELL_H);
    assign col_match = ({1'b0, idx_reg} < 4'(COLS)) && (x_reg > col_lo) && (x_reg < col_hi);
    assign row_match = ({1'b0, idx_reg} < 4'(ROWS)) && (y_reg > row_lo) && (y_reg < row_hi);

    // Layout table: {code[3:0], is_digit, is_op}; anything unlisted decodes as 4'hF.
    function automatic logic [5:0] decode(input logic [2:0] r, input logic [2:0] c);
        logic [5:0] v;
        v = {4'hF, 2'b00};
        case ({r, c})
            6'o00: v = {4'd7,  2'b10};
            6'o01: v = {4'd8,  2'b10};
            6'o02: v = {4'd9,  2'b10};
            6'o03: v = {4'd1,  2'b01};
            6'o04: v = {4'd4,  2'b01};
            6'o10: v = {4'd4,  2'b10};
            6'o11: v = {4'd5,  2'b10};
            6'o12: v = {4'd6,  2'b10};
            6'o13: v = {4'd2,  2'b01};
            6'o14: v = {4'd3,  2'b01};
            6'o20: v = {4'd1,  2'b10};
            6'o21: v = {4'd2,  2'b10};
            6'o22: v = {4'd3,  2'b10};
            6'o24: v = {4'd14, 2'b01};
            6'o30: v = {4'd0,  2'b10};
            default: v = {4'hF, 2'b00};
        endcase
        return v;
    endfunction

    assign lut = decode(row_reg, col_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (press) state_next = SCAN;
            SCAN:     if (scan_last)
                          state_next = ((colhit_reg | col_match) & (rowhit_reg | row_match))
                                       ? EMIT : WAIT_REL;
            EMIT:     state_next = WAIT_REL;
            WAIT_REL: if (!any_click) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

`ifdef KEY_REPEAT_EN
    logic [31:0] hold_cnt_reg;
    logic        armed_reg;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clicked_q_reg <= 1'b0;
            x_reg         <= '0;
            y_reg         <= '0;
            idx_reg       <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            colhit_reg    <= 1'b0;
            rowhit_reg    <= 1'b0;
            key_valid_reg <= 1'b0;
            key_code_reg  <= '0;
            is_digit_reg  <= 1'b0;
            is_op_reg     <= 1'b0;
            key_row_reg   <= '0;
            key_col_reg   <= '0;
`ifdef KEY_REPEAT_EN
            hold_cnt_reg  <= '0;
            armed_reg     <= 1'b0;
`endif
        end else begin
            clicked_q_reg <= any_click;
            key_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: if (press) begin
                    x_reg      <= {2'b00, kp.Xlocation};
                    y_reg      <= {3'b000, kp.Ylocation};
                    idx_reg    <= '0;
                    row_reg    <= '0;
                    col_reg    <= '0;
                    colhit_reg <= 1'b0;
                    rowhit_reg <= 1'b0;
`ifdef KEY_REPEAT_EN
                    armed_reg  <= 1'b0;
`endif
                end
                SCAN: begin
                    idx_reg <= idx_reg + 3'd1;
                    if (col_match) begin
                        col_reg    <= idx_reg;
                        colhit_reg <= 1'b1;
                    end
                    if (row_match) begin
                        row_reg    <= idx_reg;
                        rowhit_reg <= 1'b1;
                    end
                end
                EMIT: begin
                    key_valid_reg <= 1'b1;
                    key_code_reg  <= lut[5:2];
                    is_digit_reg  <= lut[1];
                    is_op_reg     <= lut[0];
                    key_row_reg   <= row_reg;
                    key_col_reg   <= col_reg;
`ifdef KEY_REPEAT_EN
                    armed_reg     <= 1'b1;
                    hold_cnt_reg  <= '0;
`endif
                end
                WAIT_REL: begin
`ifdef KEY_REPEAT_EN
                    // Only a hit arms repeat; the held outputs already carry the key.
                    if (any_click && armed_reg) begin
                        if (hold_cnt_reg == 32'(REPEAT_CYCLES - 1)) begin
                            key_valid_reg <= 1'b1;
                            hold_cnt_reg  <= '0;
                        end else begin
                            hold_cnt_reg  <= hold_cnt_reg + 32'd1;
                        end
                    end else begin
                        hold_cnt_reg <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign kp.key_valid = key_valid_reg;
    assign kp.key_code  = key_code_reg;
    assign kp.is_digit  = is_digit_reg;
    assign kp.is_op     = is_op_reg;
    assign kp.key_row   = key_row_reg;
    assign kp.key_col   = key_col_reg;
    assign kp.busy      = (state_reg == SCAN) || (state_reg == EMIT);
endmodule

// File: tb/tb_keypad_hit_scanner.sv
// Directed bench for keypad_hit_scanner: latency, layout decode, misses, hold/re-press, reset.
module tb_keypad_hit_scanner;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ev_cnt = 0;
    int   base;

    keypad_hit_scanner_if kp();

    keypad_hit_scanner #(.REPEAT_CYCLES(20)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kp      (kp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (kp.key_valid) ev_cnt <= ev_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press, verify busy and the key_valid cycle, release, verify held outputs and event count.
    task automatic press_chk(input string tag, input int x, input int y, input logic exp_valid,
                             input int code, input logic dig, input logic op,
                             input int row, input int col);
        int b;
        b = ev_cnt;
        @(negedge clk);
        kp.Xlocation = 10'(x);
        kp.Ylocation = 9'(y);
        kp.clicked   = 3'b001;
        wait_neg(1);
        chk({tag, "_busy"}, 32'(kp.busy), 32'd1);
        wait_neg(5);
        chk({tag, "_early"}, 32'(kp.key_valid), 32'd0);
        wait_neg(1);
        chk({tag, "_valid"}, 32'(kp.key_valid), 32'(exp_valid));
        chk({tag, "_code"}, 32'(kp.key_code), 32'(code));
        chk({tag, "_digit"}, 32'(kp.is_digit), 32'(dig));
        chk({tag, "_op"}, 32'(kp.is_op), 32'(op));
        chk({tag, "_row"}, 32'(kp.key_row), 32'(row));
        chk({tag, "_col"}, 32'(kp.key_col), 32'(col));
        kp.clicked = 3'b000;
        wait_neg(3);
        chk({tag, "_events"}, 32'(ev_cnt - b), 32'(exp_valid));
        chk({tag, "_idle"}, 32'(kp.busy), 32'd0);
        $display("press %s at (%0d,%0d): valid=%0d code=%0h row=%0d col=%0d",
                 tag, x, y, exp_valid, kp.key_code, kp.key_row, kp.key_col);
    endtask

    initial begin
        kp.clicked   = 3'b000;
        kp.Xlocation = '0;
        kp.Ylocation = '0;
        wait_neg(3);
        chk("rst_valid", 32'(kp.key_valid), 32'd0);
        chk("rst_busy",  32'(kp.busy), 32'd0);
        reset_n = 1'b1;
        wait_neg(2);
        chk("rst_code",  32'(kp.key_code), 32'd0);
        chk("rst_flags", {30'd0, kp.is_digit, kp.is_op}, 32'd0);
        chk("rst_rc",    {26'd0, kp.key_row, kp.key_col}, 32'd0);
        chk("rst_busy2", 32'(kp.busy), 32'd0);
        $display("reset: outputs cleared");

        press_chk("d7",    200, 210, 1'b1, 7,  1'b1, 1'b0, 0, 1'b0 ? 1 : 0);
        press_chk("plus",  384, 263, 1'b1, 2,  1'b0, 1'b1, 1, 3);
        press_chk("eq",    440, 330, 1'b1, 14, 1'b0, 1'b1, 2, 4);
        press_chk("unmap", 250, 410, 1'b1, 15, 1'b0, 1'b0, 3, 1);
        press_chk("line",  238, 210, 1'b0, 15, 1'b0, 1'b0, 3, 1);
        press_chk("out",   100, 100, 1'b0, 15, 1'b0, 1'b0, 3, 1);

        // Long hold, then a quick re-press
        base = ev_cnt;
        @(negedge clk);
        kp.Xlocation = 10'd200;
        kp.Ylocation = 9'd210;
        kp.clicked   = 3'b100;
        wait_neg(100);
        kp.clicked = 3'b000;
        wait_neg(2);
`ifdef KEY_REPEAT_EN
        chk("hold100_events", 32'(ev_cnt - base), 32'd5);
`else
        chk("hold100_events", 32'(ev_cnt - base), 32'd1);
`endif
        chk("hold100_code", 32'(kp.key_code), 32'd7);
        $display("hold 100 cycles: events=%0d", ev_cnt - base);
        base = ev_cnt;
        kp.Xlocation = 10'd384;
        kp.Ylocation = 9'd263;
        kp.clicked   = 3'b010;
        wait_neg(10);
        kp.clicked = 3'b000;
        wait_neg(3);
        chk("repress_events", 32'(ev_cnt - base), 32'd1);
        chk("repress_code", 32'(kp.key_code), 32'd2);
        $display("re-press after release: events=%0d code=%0h", ev_cnt - base, kp.key_code);

        // Release and press again mid-scan with the pointer moved: must be ignored
        base = ev_cnt;
        kp.Xlocation = 10'd440;
        kp.Ylocation = 9'd330;
        kp.clicked   = 3'b001;
        wait_neg(2);
        kp.clicked = 3'b000;
        wait_neg(1);
        kp.Xlocation = 10'd200;
        kp.Ylocation = 9'd210;
        kp.clicked   = 3'b001;
        wait_neg(8);
        kp.clicked = 3'b000;
        wait_neg(3);
        chk("midscan_events", 32'(ev_cnt - base), 32'd1);
        chk("midscan_code", 32'(kp.key_code), 32'd14);
        $display("press during scan: events=%0d code=%0h", ev_cnt - base, kp.key_code);

        // 70-cycle hold: auto-repeat every 20 cycles when enabled
        base = ev_cnt;
        kp.Xlocation = 10'd200;
        kp.Ylocation = 9'd210;
        kp.clicked   = 3'b001;
        wait_neg(70);
        kp.clicked = 3'b000;
        wait_neg(3);
`ifdef KEY_REPEAT_EN
        chk("hold70_events", 32'(ev_cnt - base), 32'd4);
`else
        chk("hold70_events", 32'(ev_cnt - base), 32'd1);
`endif
        $display("hold 70 cycles: events=%0d", ev_cnt - base);

        // Reset during SCAN: no event
        base = ev_cnt;
        kp.Xlocation = 10'd384;
        kp.Ylocation = 9'd263;
        kp.clicked   = 3'b001;
        wait_neg(3);
        chk("rstscan_busy_before", 32'(kp.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstscan_busy", 32'(kp.busy), 32'd0);
        chk("rstscan_code", 32'(kp.key_code), 32'd0);
        kp.clicked = 3'b000;
        wait_neg(2);
        reset_n = 1'b1;
        wait_neg(10);
        chk("rstscan_events", 32'(ev_cnt - base), 32'd0);
        $display("reset during scan: events=%0d", ev_cnt - base);

        // Button held across reset release counts as a press
        base = ev_cnt;
        reset_n = 1'b0;
        kp.Xlocation = 10'd440;
        kp.Ylocation = 9'd330;
        kp.clicked   = 3'b001;
        wait_neg(2);
        reset_n = 1'b1;
        wait_neg(9);
        kp.clicked = 3'b000;
        wait_neg(3);
        chk("heldrst_events", 32'(ev_cnt - base), 32'd1);
        chk("heldrst_code", 32'(kp.key_code), 32'd14);
        $display("held through reset: events=%0d code=%0h", ev_cnt - base, kp.key_code);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
